// File: rtl/cav_demod.sv
// -----------------------------------------------------------------------------
// cav_demod
//
// Receive-side demodulator for the cavity mode model. An interleaved
// probe/reflected IF stream (one 19-bit sample per clock, probe when iq=1,
// reflected when iq=0) is mixed to baseband against a supplied LO cos/sin
// pair, boxcar-summed over navg+1 sample pairs, and handed out as one
// four-component result per window over a valid/ready handshake.
//
// Pipeline: input register (+1), product register (+2), accumulate (+3),
// result register (+4). enable, iq and navg travel down the pipe with their
// sample so every decision refers to the sample it belongs to.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   enable              low discards any partial window and idles the block
//   iq                  1 = probe sample, 0 = reflected sample
//   adc                 signed 19-bit IF sample
//   lo_cos, lo_sin      signed 18-bit LO vector, constant across a pair
//   navg                window length minus one (pairs), latched per window
//   out_ready           consumer accepts the current result
//   overrun_clr         clears the sticky overrun flag
//   out_valid           result registers hold an unconsumed window
//   probe_i/q, refl_i/q signed ACCW-bit window sums
//   overrun             sticky: a completed window was dropped
//   sync_err            one-cycle pulse on an iq alternation violation
// -----------------------------------------------------------------------------
module cav_demod #(
    parameter int ACCW = 28
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   enable,
    input  logic                   iq,
    input  logic signed [18:0]     adc,
    input  logic signed [17:0]     lo_cos,
    input  logic signed [17:0]     lo_sin,
    input  logic [7:0]             navg,
    input  logic                   out_ready,
    input  logic                   overrun_clr,
    output logic                   out_valid,
    output logic signed [ACCW-1:0] probe_i,
    output logic signed [ACCW-1:0] probe_q,
    output logic signed [ACCW-1:0] refl_i,
    output logic signed [ACCW-1:0] refl_q,
    output logic                   overrun,
    output logic                   sync_err
);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_ACCUM = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // Stage 1: input register
    // ------------------------------------------------------------------
    logic               s1_vld;
    logic               s1_iq;
    logic signed [18:0] s1_adc;
    logic signed [17:0] s1_cos;
    logic signed [17:0] s1_sin;
    logic [7:0]         s1_navg;

    // NOTE: every register below is written with <= so all stages update
    // from pre-edge values; blocking assignments here would collapse stages.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld  <= 1'b0;
            s1_iq   <= 1'b0;
            s1_adc  <= '0;
            s1_cos  <= '0;
            s1_sin  <= '0;
            s1_navg <= '0;
        end else begin
            s1_vld  <= enable;
            s1_iq   <= iq;
            s1_adc  <= adc;
            s1_cos  <= lo_cos;
            s1_sin  <= lo_sin;
            s1_navg <= navg;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: mix to baseband, adc * (cos - j sin), floor-shifted by 17
    // ------------------------------------------------------------------
    logic signed [36:0] prod_i;
    logic signed [36:0] prod_q;
    logic signed [19:0] mix_i;
    logic signed [19:0] mix_q;

    // NOTE: every always_comb output gets a value on every path; assigning
    // all of them up front is what keeps latches from being inferred.
    always_comb begin
        prod_i = 37'(s1_adc) * 37'(s1_cos);
        prod_q = 37'(s1_adc) * 37'(s1_sin);
        // Bits [36:17] are the arithmetic shift by 17; the magnitude never
        // exceeds 2^18, so 20 signed bits hold both the value and its negation.
        mix_i  = prod_i[36:17];
        mix_q  = -prod_q[36:17];
    end

    logic               p_vld;
    logic               p_iq;
    logic signed [19:0] p_i;
    logic signed [19:0] p_q;
    logic [7:0]         p_navg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_vld  <= 1'b0;
            p_iq   <= 1'b0;
            p_i    <= '0;
            p_q    <= '0;
            p_navg <= '0;
        end else begin
            p_vld  <= s1_vld;
            p_iq   <= s1_iq;
            p_i    <= mix_i;
            p_q    <= mix_q;
            p_navg <= s1_navg;
        end
    end

    // ------------------------------------------------------------------
    // Stage 3: window state machine and accumulators
    // ------------------------------------------------------------------
    state_t                state;
    logic                  last_iq;
    logic [7:0]            cnt;
    logic [7:0]            navg_lat;
    logic                  dump;
    logic signed [ACCW-1:0] acc_pi;
    logic signed [ACCW-1:0] acc_pq;
    logic signed [ACCW-1:0] acc_ri;
    logic signed [ACCW-1:0] acc_rq;
    logic signed [ACCW-1:0] ext_i;
    logic signed [ACCW-1:0] ext_q;
    logic signed [ACCW-1:0] base_pi;
    logic signed [ACCW-1:0] base_pq;
    logic signed [ACCW-1:0] base_ri;
    logic signed [ACCW-1:0] base_rq;

    // While a dump is pending the accumulators still hold the finished
    // window (the result stage reads them this cycle), so a probe sample
    // that opens the next window must add onto zero instead.
    always_comb begin
        ext_i   = ACCW'(p_i);
        ext_q   = ACCW'(p_q);
        base_pi = dump ? '0 : acc_pi;
        base_pq = dump ? '0 : acc_pq;
        base_ri = dump ? '0 : acc_ri;
        base_rq = dump ? '0 : acc_rq;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            last_iq  <= 1'b0;
            cnt      <= '0;
            navg_lat <= '0;
            dump     <= 1'b0;
            sync_err <= 1'b0;
            acc_pi   <= '0;
            acc_pq   <= '0;
            acc_ri   <= '0;
            acc_rq   <= '0;
        end else begin
            dump     <= 1'b0;
            sync_err <= 1'b0;
            if (!p_vld) begin
                // Disabled sample: drop the partial window.
                state  <= S_IDLE;
                cnt    <= '0;
                acc_pi <= '0;
                acc_pq <= '0;
                acc_ri <= '0;
                acc_rq <= '0;
            end else if (state == S_IDLE || p_iq == last_iq) begin
                // Either waiting for a window start, or an alternation
                // violation. Outside IDLE a violation is flagged and the
                // partial window discarded; a probe sample starts afresh.
                if (state == S_ACCUM) begin
                    sync_err <= 1'b1;
                end
                cnt     <= '0;
                acc_ri  <= '0;
                acc_rq  <= '0;
                last_iq <= p_iq;
                if (p_iq) begin
                    state    <= S_ACCUM;
                    navg_lat <= p_navg;
                    acc_pi   <= ext_i;
                    acc_pq   <= ext_q;
                end else begin
                    state  <= S_IDLE;
                    acc_pi <= '0;
                    acc_pq <= '0;
                end
            end else if (p_iq) begin
                // Probe half of a pair; directly after a dump this is the
                // first sample of the next window.
                if (dump) begin
                    navg_lat <= p_navg;
                end
                acc_pi  <= base_pi + ext_i;
                acc_pq  <= base_pq + ext_q;
                acc_ri  <= base_ri;
                acc_rq  <= base_rq;
                last_iq <= 1'b1;
            end else begin
                // Reflected half closes a pair.
                acc_ri  <= acc_ri + ext_i;
                acc_rq  <= acc_rq + ext_q;
                last_iq <= 1'b0;
                if (cnt == navg_lat) begin
                    dump <= 1'b1;
                    cnt  <= '0;
                end else begin
                    cnt <= cnt + 8'd1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 4: result registers and handshake
    // ------------------------------------------------------------------
    logic drop;
    assign drop = dump && out_valid && !out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            overrun   <= 1'b0;
            probe_i   <= '0;
            probe_q   <= '0;
            refl_i    <= '0;
            refl_q    <= '0;
        end else begin
            if (dump && (!out_valid || out_ready)) begin
                out_valid <= 1'b1;
                probe_i   <= acc_pi;
                probe_q   <= acc_pq;
                refl_i    <= acc_ri;
                refl_q    <= acc_rq;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            // A drop in the same cycle as a clear leaves the flag set.
            overrun <= drop | (overrun & ~overrun_clr);
        end
    end

endmodule

// File: tb/tb_cav_demod.sv
// -----------------------------------------------------------------------------
// tb_cav_demod
//
// Directed-vector bench for cav_demod. Inputs change 1 ns after the rising
// edge; outputs are read 1 ns after an edge or on the falling edge. A
// falling-edge monitor logs every handshake transfer and every sync_err pulse.
// Expected sums are hand-computed: for 0 < adc <= 131072 with lo_cos=131071
// each mixed I term is adc-1; adc=65536 with a 131071 LO gives 65535.
// -----------------------------------------------------------------------------
module tb_cav_demod;

    localparam int ACCW = 28;

    logic                   clk;
    logic                   rst_n;
    logic                   enable;
    logic                   iq;
    logic signed [18:0]     adc;
    logic signed [17:0]     lo_cos;
    logic signed [17:0]     lo_sin;
    logic [7:0]             navg;
    logic                   out_ready;
    logic                   overrun_clr;
    logic                   out_valid;
    logic signed [ACCW-1:0] probe_i;
    logic signed [ACCW-1:0] probe_q;
    logic signed [ACCW-1:0] refl_i;
    logic signed [ACCW-1:0] refl_q;
    logic                   overrun;
    logic                   sync_err;

    cav_demod #(.ACCW(ACCW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .iq          (iq),
        .adc         (adc),
        .lo_cos      (lo_cos),
        .lo_sin      (lo_sin),
        .navg        (navg),
        .out_ready   (out_ready),
        .overrun_clr (overrun_clr),
        .out_valid   (out_valid),
        .probe_i     (probe_i),
        .probe_q     (probe_q),
        .refl_i      (refl_i),
        .refl_q      (refl_q),
        .overrun     (overrun),
        .sync_err    (sync_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Transfer log and sync_err pulse count
    longint q_pi[$];
    longint q_pq[$];
    longint q_ri[$];
    longint q_rq[$];
    int     q_cyc[$];
    int     n_sync = 0;

    always @(negedge clk) begin
        if (sync_err) n_sync++;
        if (out_valid && out_ready) begin
            q_pi.push_back(probe_i);
            q_pq.push_back(probe_q);
            q_ri.push_back(refl_i);
            q_rq.push_back(refl_q);
            q_cyc.push_back(cyc);
        end
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        else n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic i_iq, input logic signed [18:0] a,
                       input logic signed [17:0] c, input logic signed [17:0] s);
        enable = 1'b1;
        iq     = i_iq;
        adc    = a;
        lo_cos = c;
        lo_sin = s;
        tick();
    endtask

    task automatic pairs(input int n, input logic signed [18:0] a,
                         input logic signed [17:0] c, input logic signed [17:0] s);
        for (int k = 0; k < n; k++) begin
            put(1'b1, a, c, s);
            put(1'b0, a, c, s);
        end
    endtask

    task automatic idle(input int n);
        enable = 1'b0;
        iq     = 1'b0;
        adc    = '0;
        repeat (n) tick();
    endtask

    task automatic clear_log();
        q_pi.delete();
        q_pq.delete();
        q_ri.delete();
        q_rq.delete();
        q_cyc.delete();
    endtask

    initial begin
        rst_n       = 1'b0;
        enable      = 1'b0;
        iq          = 1'b0;
        adc         = '0;
        lo_cos      = '0;
        lo_sin      = '0;
        navg        = '0;
        out_ready   = 1'b1;
        overrun_clr = 1'b0;
        #2;
        check("rst out_valid", out_valid, 0);
        check("rst overrun", overrun, 0);
        check("rst sync_err", sync_err, 0);
        check("rst probe_i", probe_i, 0);
        check("rst refl_q", refl_q, 0);
        repeat (3) tick();
        rst_n = 1'b1;
        idle(2);

        // ---- Single pair, latency ----
        navg = 8'd0;
        put(1'b1, 65536, 131071, 0);
        put(1'b0, 65536, 131071, 0);
        idle(2);
        check("t1 valid early", out_valid, 0);
        tick();
        check("t1 valid at +4", out_valid, 1);
        check("t1 probe_i", probe_i, 65535);
        check("t1 refl_i", refl_i, 65535);
        check("t1 probe_q", probe_q, 0);
        check("t1 refl_q", refl_q, 0);
        idle(2);
        check("t1 valid after xfer", out_valid, 0);

        // ---- Averaging, Q sign, back-to-back windows ----
        clear_log();
        n_sync = 0;
        navg = 8'd3;
        pairs(20, 65536, 0, 131071);
        idle(6);
        check("t2 window count", q_pq.size(), 5);
        for (int k = 0; k < 5; k++) begin
            check($sformatf("t2 w%0d probe_q", k), q_pq[k], -262140);
            check($sformatf("t2 w%0d refl_q", k), q_rq[k], -262140);
            check($sformatf("t2 w%0d probe_i", k), q_pi[k], 0);
            check($sformatf("t2 w%0d refl_i", k), q_ri[k], 0);
        end
        for (int k = 1; k < 5; k++)
            check($sformatf("t2 spacing %0d", k), q_cyc[k] - q_cyc[k-1], 8);
        check("t2 no sync_err", n_sync, 0);

        // ---- Overrun: three windows with consumer stalled ----
        navg = 8'd0;
        out_ready = 1'b0;
        pairs(1, 1000, 131071, 0);
        pairs(1, 2000, 131071, 0);
        pairs(1, 3000, 131071, 0);
        check("t3 first held valid", out_valid, 1);
        check("t3 no overrun yet", overrun, 0);
        check("t3 first probe_i", probe_i, 999);
        idle(1);
        check("t3 overrun after 2nd", overrun, 1);
        check("t3 probe_i held", probe_i, 999);
        idle(3);
        check("t3 refl_i held", refl_i, 999);
        check("t3 overrun sticky", overrun, 1);
        overrun_clr = 1'b1;
        tick();
        overrun_clr = 1'b0;
        check("t3 overrun cleared", overrun, 0);
        out_ready = 1'b1;
        tick();
        check("t3 valid after xfer", out_valid, 0);

        // ---- Dump coincident with a transfer ----
        clear_log();
        out_ready = 1'b0;
        pairs(1, 1000, 131071, 0);
        idle(4);
        check("t3c held valid", out_valid, 1);
        pairs(1, 4000, 131071, 0);
        idle(2);
        out_ready = 1'b1;
        idle(1);
        check("t3c valid kept", out_valid, 1);
        check("t3c new probe_i", probe_i, 3999);
        check("t3c no overrun", overrun, 0);
        idle(2);
        check("t3c valid drops", out_valid, 0);
        check("t3c xfer count", q_pi.size(), 2);
        check("t3c xfer0", q_pi[0], 999);
        check("t3c xfer1", q_pi[1], 3999);

        // ---- Sync error: iq = 1,0,1,1,0,... ----
        clear_log();
        n_sync = 0;
        navg = 8'd1;
        put(1'b1, 100, 131071, 0);
        put(1'b0, 200, 131071, 0);
        put(1'b1, 300, 131071, 0);
        put(1'b1, 1000, 131071, 0);
        put(1'b0, 2000, 131071, 0);
        check("t4 no pulse yet", sync_err, 0);
        put(1'b1, 3000, 131071, 0);
        check("t4 pulse", sync_err, 1);
        put(1'b0, 4000, 131071, 0);
        check("t4 pulse ends", sync_err, 0);
        idle(6);
        check("t4 one pulse", n_sync, 1);
        check("t4 one result", q_pi.size(), 1);
        check("t4 probe_i", q_pi[0], 3998);
        check("t4 refl_i", q_ri[0], 5998);

        // ---- Reset mid-window ----
        out_ready = 1'b0;
        navg = 8'd0;
        pairs(1, 1000, 131071, 0);
        idle(4);
        check("t5r pre valid", out_valid, 1);
        navg = 8'd7;
        pairs(3, 65536, 131071, 0);
        rst_n = 1'b0;
        #1;
        check("t5r valid", out_valid, 0);
        check("t5r probe_i", probe_i, 0);
        check("t5r refl_i", refl_i, 0);
        check("t5r overrun", overrun, 0);
        check("t5r sync_err", sync_err, 0);
        idle(1);
        rst_n = 1'b1;
        out_ready = 1'b1;
        idle(2);
        clear_log();
        pairs(8, 65536, 131071, 0);
        idle(6);
        check("t5r one result", q_pi.size(), 1);
        check("t5r probe_i", q_pi[0], 524280);
        check("t5r refl_i", q_ri[0], 524280);
        check("t5r probe_q", q_pq[0], 0);

        // ---- Enable drop mid-window ----
        out_ready = 1'b0;
        navg = 8'd0;
        pairs(1, 2000, 131071, 0);
        idle(4);
        navg = 8'd7;
        pairs(3, 65536, 131071, 0);
        idle(3);
        check("t5e valid kept", out_valid, 1);
        check("t5e probe_i kept", probe_i, 1999);
        check("t5e refl_i kept", refl_i, 1999);
        out_ready = 1'b1;
        tick();
        clear_log();
        pairs(8, 65536, 131071, 0);
        idle(6);
        check("t5e one result", q_pi.size(), 1);
        check("t5e probe_i", q_pi[0], 524280);
        check("t5e refl_i", q_ri[0], 524280);

        // ---- Extremes, full 256-pair window ----
        clear_log();
        n_sync = 0;
        navg = 8'd255;
        pairs(256, -262144, -131072, -131072);
        idle(6);
        check("t6 one result", q_pi.size(), 1);
        check("t6 probe_i", q_pi[0], 67108864);
        check("t6 probe_q", q_pq[0], -67108864);
        check("t6 refl_i", q_ri[0], 67108864);
        check("t6 refl_q", q_rq[0], -67108864);
        check("t6 no sync_err", n_sync, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/cav_demod.md
# cav_demod

Receive-side counterpart of the cavity mode model. It takes the interleaved probe/reflected IF stream, one 19-bit sample per clock (probe when `iq`=1, reflected when `iq`=0), and mixes each sample to baseband with a supplied LO cos/sin pair. It then boxcar-accumulates over a programmable number of sample pairs and presents one four-component result per window over a valid/ready handshake. It sits between the simulated (or real) ADC stream and the feedback/monitor logic.

## Interface
- `ACCW`, 28: accumulator and output width.
- `clk` input 1: single clock, all logic rising-edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `enable` input 1: low forces IDLE and discards any partial window.
- `iq` input 1: high = probe sample, low = reflected sample; must alternate.
- `adc` input signed 19: IF sample.
- `lo_cos`, `lo_sin` input signed 18 each: LO vector. Must be held constant across a probe/refl pair, changing only with the probe sample.
- `navg` input 8: window length is `navg`+1 pairs; sampled at window start.
- `out_ready` input 1: consumer accepts the result.
- `overrun_clr` input 1: clears `overrun`.
- `out_valid` output 1: result registers hold an unconsumed window.
- `probe_i`, `probe_q`, `refl_i`, `refl_q` output signed ACCW each: window sums.
- `overrun` output 1: sticky flag; a completed window was dropped.
- `sync_err` output 1: one-cycle pulse on an `iq` alternation violation.

## Operation
- Mixing is baseband = adc·(cos − j·sin):
  - i = (adc·lo_cos) >>> 17
  - q = −((adc·lo_sin) >>> 17)
  - Products are 37-bit, arithmetic shift (floor), kept as 20-bit signed.
- Sums accumulate sign-extended into ACCW bits with no saturation; ACCW=28 covers 256 pairs × 20 bits exactly.
- State machine:
  - IDLE: accumulators zero, pair counter zero. Leave to ACCUM on the first `iq`=1 sample while `enable`=1; that sample is accumulated. Latch `navg`.
  - ACCUM: accumulate the probe sample into `probe_*` and the refl sample into `refl_*`. The counter increments after each refl sample.
  - When the counter reaches the latched `navg`+1, dump the sums to the result registers and clear the accumulators. If the next cycle is a probe sample, go directly to ACCUM for the next window with no gap, re-latching `navg`.
- Alternation rule: two consecutive samples with equal `iq`, or a first sample with `iq`=0 after leaving IDLE, causes:
  - `sync_err` pulse
  - partial window discarded
  - return to IDLE
  - The offending sample, if it has `iq`=1, starts the new window.
- Handshake:
  - `out_valid` rises on dump.
  - Transfer occurs when `out_valid`&`out_ready`; `out_valid` falls the following cycle unless a dump lands in that same cycle.
  - Dump with `out_valid`=1 and no transfer: the new result is dropped, old outputs are held unchanged, and `overrun` is set.
  - Dump coincident with a transfer: new result loaded, `out_valid` stays 1, no overrun.
- `overrun_clr` clears `overrun`. If a drop occurs in the same cycle, set wins.
- `enable` falling mid-window: partial sums discarded, IDLE next cycle. Result registers and `out_valid` are unaffected.

## Timing
- Pipeline:
  - input register at +1
  - product register at +2
  - accumulate at +3
  - dump/result register at +4
- `out_valid` is 1 in the 4th cycle after the cycle the window's last refl sample is presented.
- Throughput: one sample per clock, continuous. Back-to-back windows lose no samples.
- Reset (async, `rst_n`=0) sets:
  - all outputs 0: `out_valid`=0, `overrun`=0, `sync_err`=0, result registers 0
  - state IDLE, accumulators and counter 0, pipeline registers 0
- Release of reset is synchronous to `clk`. The first accepted sample is the first `iq`=1 sample presented at least one cycle after release.
- Reset mid-window: everything is cleared immediately, with no output pulse.

## Test plan
- Single pair: `navg`=0, `adc`=65536, `lo_cos`=131071, `lo_sin`=0 on both samples. Required: `probe_i`=`refl_i`=65535 and `probe_q`=`refl_q`=0, with `out_valid` 4 cycles after the refl sample.
- Averaging and Q sign: `navg`=3, `adc`=65536, `lo_cos`=0, `lo_sin`=131071 constant. Required: `probe_q`=`refl_q`=−262140 and both I components 0, with exactly one result per 8 samples over 5 consecutive windows and no sample lost.
- Overrun: `navg`=0, `out_ready` held low for 3 windows. Required: the first result is held, `overrun`=1 after the second dump, and `overrun_clr` clears it. A dump coincident with `out_ready`=1 loads the new value with no overrun.
- Sync error: the sequence `iq`=1,0,1,1,0 with `navg`=1. Required: a single `sync_err` pulse at the second consecutive `iq`=1, no `out_valid` for the discarded partial window, and the window restarting at that sample.
- Reset/enable mid-window: `navg`=7, assert `rst_n`=0 (or drop `enable`) after 3 pairs. Required: reset zeroes all outputs immediately; the `enable` case leaves the prior result intact. The next full window yields the exact 8-pair sum with no carry-over.
- Extremes: `adc`=−262144 with `lo_cos`=`lo_sin`=−131072, `navg`=255. Required: sums are bit-exact against the reference model with no wrap.
